// File: rtl/spike_cmd_rx.sv
// AXI-Stream command receiver: buffers host words in a small FIFO and decodes them into
// force-spike, time-step and select stimulus for the spiking network.
module spike_cmd_rx #(
  parameter int TDATA_W    = 16,
  parameter int BLOCK_W    = 2,
  parameter int N          = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int NEURON_W  = $clog2(N)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [TDATA_W-1:0]  s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  output logic                select,
  output logic [BLOCK_W-1:0]  force_spike_block_select,
  output logic [NEURON_W-1:0] force_spike_neuron_select,
  output logic                force_spike_en,
  output logic                time_step,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

  logic [TDATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                tready_q, tready_d;
  logic                select_q, select_d;
  logic                en_q, en_d;
  logic                ts_q, ts_d;
  logic [BLOCK_W-1:0]  blk_q, blk_d;
  logic [NEURON_W-1:0] nrn_q, nrn_d;
  logic [7:0]          err_q, err_d;

  logic                push, pop, empty, force_ok;
  logic [TDATA_W-1:0]  head;
  logic [1:0]          op;
  logic [5:0]          hi_bits;
  logic                unused_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push    = s_tvalid & tready_q;
  assign head    = mem[rd_ptr_q[AW-1:0]];
  assign op      = head[15:14];
  assign hi_bits = head[13:8];
  // Neuron range is checked on the whole low byte so out-of-range indices cannot alias.
  assign force_ok = ({24'd0, head[7:0]} < 32'(N)) && ((hi_bits >> BLOCK_W) == '0);
  assign unused_ok = s_tlast;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    blk_d    = blk_q;
    nrn_d    = nrn_q;
    err_d    = err_q;
    en_d     = 1'b0;
    ts_d     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          case (op)
            2'b01: begin
              if (force_ok) begin
                en_d  = 1'b1;
                blk_d = head[8 +: BLOCK_W];
                nrn_d = head[NEURON_W-1:0];
              end else if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
              end
            end
            2'b10: begin
              ts_d  = 1'b1;
              cnt_d = head[7:0];
              if (head[7:0] != 8'd0) state_d = WAIT;
            end
            2'b11:   select_d = head[0];
            default: ;
          endcase
        end
      end
      EXEC: state_d = IDLE;
      WAIT: begin
        // Leaving when the count reads 1 yields exactly hold stall cycles.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    tready_d = ((wr_ptr_d ^ rd_ptr_d) != {1'b1, {AW{1'b0}}});
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tready_q <= 1'b0;
      select_q <= 1'b0;
      en_q     <= 1'b0;
      ts_q     <= 1'b0;
      blk_q    <= '0;
      nrn_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tready_q <= tready_d;
      select_q <= select_d;
      en_q     <= en_d;
      ts_q     <= ts_d;
      blk_q    <= blk_d;
      nrn_q    <= nrn_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= s_tdata;
  end

  assign s_tready                  = tready_q;
  assign select                    = select_q;
  assign force_spike_block_select  = blk_q;
  assign force_spike_neuron_select = nrn_q;
  assign force_spike_en            = en_q;
  assign time_step                 = ts_q;
  assign busy                      = (state_q != IDLE) || !empty;
  assign err_cnt                   = err_q;

endmodule

// File: tb/tb_spike_cmd_rx.sv
// Scoreboard bench for spike_cmd_rx: the driver predicts output events per accepted word,
// a negedge monitor pops and compares them as the DUT emits pulses or select changes.
module tb_spike_cmd_rx;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready, select, force_spike_en, time_step, busy;
  logic [1:0]  force_spike_block_select;
  logic [3:0]  force_spike_neuron_select;
  logic [7:0]  err_cnt;

  spike_cmd_rx #(.TDATA_W(16), .BLOCK_W(2), .N(16), .FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast), .select(select),
    .force_spike_block_select(force_spike_block_select),
    .force_spike_neuron_select(force_spike_neuron_select),
    .force_spike_en(force_spike_en), .time_step(time_step), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // kind: 0 force pulse, 1 time_step pulse, 2 select change; at < 0 means timing not checked
  typedef struct {
    int kind;
    int blk;
    int nrn;
    int sel;
    int at;
  } ev_t;

  ev_t expq[$];
  int  errors = 0;
  int  checks = 0;
  int  m_sel = 0;
  int  m_err = 0;
  int  prev_sel = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model(input logic [15:0] w, input int acc, input int lat);
    ev_t e;
    int  at;
    at = (lat < 0) ? -1 : acc + lat;
    e.blk = 0; e.nrn = 0; e.sel = 0; e.at = at;
    case (w[15:14])
      2'b01: begin
        if (int'(w[7:0]) < 16 && w[13:10] == 4'd0) begin
          e.kind = 0; e.blk = int'(w[9:8]); e.nrn = int'(w[7:0]);
          expq.push_back(e);
        end else if (m_err < 255) begin
          m_err++;
        end
      end
      2'b10: begin
        e.kind = 1;
        expq.push_back(e);
      end
      2'b11: begin
        if (int'(w[0]) != m_sel) begin
          m_sel = int'(w[0]);
          e.kind = 2; e.sel = m_sel;
          expq.push_back(e);
        end
      end
      default: ;
    endcase
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (expq.size() == 0) begin
      chk("unexpected_event", kind, -1);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind == 0) begin
      chk("force_block", int'(force_spike_block_select), e.blk);
      chk("force_neuron", int'(force_spike_neuron_select), e.nrn);
    end
    if (kind == 2) chk("select_level", int'(select), e.sel);
    if (e.at >= 0) chk("event_cycle", cyc, e.at);
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_sel = 0;
    end else begin
      if (force_spike_en) take(0);
      if (time_step) take(1);
      if (int'(select) != prev_sel) begin
        take(2);
        prev_sel = int'(select);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] w, input int lat);
    int acc;
    int guard;
    guard = 0;
    s_tdata = w;
    s_tvalid = 1'b1;
    while (!s_tready && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    if (!s_tready) begin
      chk("tready_timeout", 0, 1);
      s_tvalid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge aclk);
    @(negedge aclk);
    model(w, acc, lat);
  endtask

  task automatic quiesce();
    int g;
    g = 0;
    s_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    while (busy && g < 500) begin
      @(negedge aclk);
      g++;
    end
    if (busy) chk("quiesce_timeout", int'(busy), 0);
    repeat (3) @(negedge aclk);
  endtask

  function automatic int outs_packed();
    return int'({s_tready, select, force_spike_block_select, force_spike_neuron_select,
                 force_spike_en, time_step, busy, err_cnt});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    repeat (3) @(negedge aclk);
    chk("reset_outputs", outs_packed(), 0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("tready_after_reset", int'(s_tready), 1);

    // single FORCE, pulse one edge after acceptance
    send(16'h4105, 1);
    quiesce();

    // back-to-back FORCE words, no bubble
    send(16'h4003, 1);
    send(16'h4007, 1);
    send(16'h4009, 1);
    quiesce();

    // STEP hold=3 delays the following FORCE by exactly 4 cycles
    send(16'h8003, 1);
    send(16'h4002, 4);
    s_tvalid = 1'b0;
    repeat (3) begin
      chk("busy_during_wait", int'(busy), 1);
      @(negedge aclk);
    end
    quiesce();

    // long stall fills the FIFO; tready drops after four accepted words
    send(16'h8014, 1);
    send(16'h4101, 21);
    send(16'h4202, 21);
    send(16'h430C, 21);
    send(16'h400F, 21);
    chk("tready_full", int'(s_tready), 0);
    chk("busy_full", int'(busy), 1);
    send(16'h4108, 3);
    quiesce();

    // rejected FORCE words count errors and do not pulse
    send(16'h4010, -1);
    quiesce();
    chk("err_cnt_bad_neuron", int'(err_cnt), 1);
    send(16'h4405, -1);
    quiesce();
    chk("err_cnt_bad_rsv", int'(err_cnt), 2);
    send(16'h4306, 1);
    quiesce();
    chk("err_cnt_after_good", int'(err_cnt), 2);

    // randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: w = {2'b00, 14'($urandom())};
        1: w = {2'b01, ($urandom_range(0, 7) == 0) ? 4'h2 : 4'h0, 2'($urandom()),
                8'($urandom_range(0, 19))};
        2: w = {2'b10, 6'($urandom()), 8'($urandom_range(0, 4))};
        default: w = {2'b11, 13'($urandom()), 1'($urandom())};
      endcase
      send(w, -1);
      if ($urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge aclk);
      end
    end
    quiesce();
    chk("err_cnt_model", int'(err_cnt), m_err);
    chk("queue_drained", expq.size(), 0);

    // reset in the middle of a STEP stall aborts everything
    send(16'hC000, -1);
    send(16'hC001, -1);
    quiesce();
    chk("select_set", int'(select), 1);
    send(16'h800A, 1);
    send(16'h4101, -1);
    s_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    #1 aresetn = 1'b0;
    #1 chk("mid_reset_outputs", outs_packed(), 0);
    expq.delete();
    m_sel = 0;
    m_err = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (40) @(negedge aclk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_select", int'(select), 0);
    chk("post_reset_tready", int'(s_tready), 1);
    chk("post_reset_queue", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
